alu: RTL and testbench
======================

// Module: alu
//
// PURPOSE
//  Parameterised 16-operation integer ALU for the CPU datapath: arithmetic, logic, shift/rotate, compare.
//  Operands and opcode are sampled on clk; result and carry are registered (1-cycle latency).
//  Sits between the register-file read ports and the writeback mux.
//
// PARAMETERS
//  REG_WIDTH   4   operand/result width in bits (>=2)
//
// PORTS
//  clk       in   1          single clock; all state updates on posedge
//  reset     in   1          synchronous, active-high reset
//  a_i       in   REG_WIDTH  operand A
//  b_i       in   REG_WIDTH  operand B
//  instr_i   in   4          opcode (table below)
//  cin_i     in   1          carry/shift-in
//  out_o     out  REG_WIDTH  registered result
//  cout_o    out  1          registered carry/flag out
//
// BEHAVIOUR
//  - reset=1 at posedge: out_o<=0, cout_o<=0 (flags <=0 too); reset wins over any operation.
//  - Otherwise each posedge: out_o/cout_o <= f(a_i,b_i,instr_i,cin_i); no handshake, new op every cycle.
//  - Arithmetic computed REG_WIDTH+1 wide; cout = bit REG_WIDTH; result wraps mod 2^REG_WIDTH.
//  - Opcode map (cout in brackets):
//    0 ADD  a+b+cin [carry]          1 SUB  a+~b+cin [carry; 1=no borrow]
//    2 INC  a+1 [carry]              3 DEC  a+all-ones [carry; 0 only if a==0]
//    4 AND  a&b [0]  5 OR a|b [0]    6 XOR a^b [0]   7 NOT ~a [0]
//    8 PASSA a [0]   9 PASSB b [0]
//    A SHL  {a[W-2:0],cin} [a[W-1]]  B SHR {cin,a[W-1:1]} [a[0]]
//    C ASR  {a[W-1],a[W-1:1]} [a[0]] D ROL {a[W-2:0],a[W-1]} [a[W-1]]
//    E ROR  {a[0],a[W-1:1]} [a[0]]   F SLTU out=(a<b unsigned)?1:0 [a==b]
//  - cin_i ignored by ops other than ADD, SUB, SHL, SHR.
//  - Inputs X/unknown are not handled specially; the design has no other state.
//
// CONFIGURATION
//  ALU_FLAGS_EN defined: adds outputs zero_o (1b, registered, =1 when next out_o==0) and
//    ovf_o (1b, registered, signed overflow for ADD/SUB/INC/DEC, 0 otherwise); both 0 on reset.
//  ALU_FLAGS_EN undefined: ports zero_o/ovf_o absent; all other behaviour identical.
//
// TESTING (REG_WIDTH=4; results checked one cycle after inputs applied)
//  reset=1 with ADD F+1 applied -> out_o=0, cout_o=0; release reset -> next cycle out_o=0, cout_o=1.
//  ADD a=F b=1 cin=0 -> out=0 cout=1; ADD a=7 b=8 cin=1 -> out=0 cout=1.
//  SUB a=5 b=3 cin=1 -> out=2 cout=1; SUB a=3 b=5 cin=1 -> out=E cout=0 (ovf_o=0 if flags en).
//  SHL a=1001 cin=1 -> out=0011 cout=1; ASR a=1000 -> out=1100 cout=0; ROR a=0001 -> out=1000 cout=1.
//  SLTU a=3 b=9 -> out=1 cout=0; a=9 b=9 -> out=0 cout=1; DEC a=0 -> out=F cout=0.
//  Back-to-back: AND A&6, then XOR A^6 on consecutive cycles -> out 2 then C, no bubble.

Source files
------------

// File: rtl/alu_if.sv
// Operand/result bundle between the register-file read ports, the ALU and writeback.
// The flag outputs zero_o/ovf_o exist only when ALU_FLAGS_EN is defined.
interface alu_if #(
  parameter int REG_WIDTH = 4
);
  logic [REG_WIDTH-1:0] a_i;
  logic [REG_WIDTH-1:0] b_i;
  logic [3:0]           instr_i;
  logic                 cin_i;
  logic [REG_WIDTH-1:0] out_o;
  logic                 cout_o;
`ifdef ALU_FLAGS_EN
  logic                 zero_o;
  logic                 ovf_o;

  modport master (output a_i, b_i, instr_i, cin_i, input out_o, cout_o, zero_o, ovf_o);
  modport slave  (input a_i, b_i, instr_i, cin_i, output out_o, cout_o, zero_o, ovf_o);
`else
  modport master (output a_i, b_i, instr_i, cin_i, input out_o, cout_o);
  modport slave  (input a_i, b_i, instr_i, cin_i, output out_o, cout_o);
`endif
endinterface

// File: rtl/alu.sv
// 16-operation registered integer ALU (1-cycle latency, new op every cycle).
// Define ALU_FLAGS_EN to add registered zero_o and signed-overflow ovf_o outputs.
module alu #(
  parameter int REG_WIDTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus
);
  localparam int W = REG_WIDTH;

  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic [W-1:0] w_addend;
  logic         w_carry_in;
  logic [W:0]   w_sum;
  logic [W-1:0] w_res;
  logic         w_cout;

  logic [W-1:0] r_out;
  logic         r_cout;

  assign w_a = bus.a_i;
  assign w_b = bus.b_i;

  // ADD/SUB/INC/DEC share one adder: only the addend and carry-in differ.
  always_comb begin
    w_addend   = w_b;
    w_carry_in = bus.cin_i;
    case (bus.instr_i[1:0])
      2'b00:   begin w_addend = w_b;        w_carry_in = bus.cin_i; end
      2'b01:   begin w_addend = ~w_b;       w_carry_in = bus.cin_i; end
      2'b10:   begin w_addend = '0;         w_carry_in = 1'b1;      end
      default: begin w_addend = {W{1'b1}};  w_carry_in = 1'b0;      end
    endcase
  end

  assign w_sum = {1'b0, w_a} + {1'b0, w_addend} + {{W{1'b0}}, w_carry_in};

  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    case (bus.instr_i)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        w_res  = w_sum[W-1:0];
        w_cout = w_sum[W];
      end
      4'h4: w_res = w_a & w_b;
      4'h5: w_res = w_a | w_b;
      4'h6: w_res = w_a ^ w_b;
      4'h7: w_res = ~w_a;
      4'h8: w_res = w_a;
      4'h9: w_res = w_b;
      4'hA: begin w_res = {w_a[W-2:0], bus.cin_i};   w_cout = w_a[W-1]; end
      4'hB: begin w_res = {bus.cin_i, w_a[W-1:1]};   w_cout = w_a[0];   end
      4'hC: begin w_res = {w_a[W-1], w_a[W-1:1]};    w_cout = w_a[0];   end
      4'hD: begin w_res = {w_a[W-2:0], w_a[W-1]};    w_cout = w_a[W-1]; end
      4'hE: begin w_res = {w_a[0], w_a[W-1:1]};      w_cout = w_a[0];   end
      default: begin
        w_res  = {{(W-1){1'b0}}, (w_a < w_b)};
        w_cout = (w_a == w_b);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_out  <= w_res;
      r_cout <= w_cout;
    end
  end

  assign bus.out_o  = r_out;
  assign bus.cout_o = r_cout;

`ifdef ALU_FLAGS_EN
  logic w_is_arith;
  logic w_ovf;
  logic r_zero;
  logic r_ovf;

  // Signed overflow: both adder inputs share a sign that the result does not.
  assign w_is_arith = (bus.instr_i[3:2] == 2'b00);
  assign w_ovf      = w_is_arith && (w_a[W-1] == w_addend[W-1]) && (w_sum[W-1] != w_a[W-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_zero <= (w_res == '0);
      r_ovf  <= w_ovf;
    end
  end

  assign bus.zero_o = r_zero;
  assign bus.ovf_o  = r_ovf;
`endif
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu at REG_WIDTH=4; flag outputs are also checked when ALU_FLAGS_EN is defined.
module tb_alu;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  alu_if #(.REG_WIDTH(4)) bus ();

  alu #(.REG_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs at the falling edge, then wait past the capturing rising edge.
  task automatic drive(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic cin);
    @(negedge clk);
    bus.instr_i = op;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.cin_i   = cin;
    @(posedge clk);
    #1;
    $display("op=%h a=%h b=%h cin=%0d -> out=%h cout=%0d", op, a, b, cin, bus.out_o, bus.cout_o);
  endtask

  // Vector layout: {op, a, b, cin, exp_out, exp_cout, exp_ovf}
  task automatic run_vectors(input string name, input logic [18:0] v[$]);
    for (int i = 0; i < v.size(); i++) begin
      drive(v[i][18:15], v[i][14:11], v[i][10:7], v[i][6]);
      n_checks++;
      if (bus.out_o !== v[i][5:2]) begin
        n_fail++;
        $display("FAIL %s[%0d] out_o: got %h expected %h", name, i, bus.out_o, v[i][5:2]);
      end
      n_checks++;
      if (bus.cout_o !== v[i][1]) begin
        n_fail++;
        $display("FAIL %s[%0d] cout_o: got %b expected %b", name, i, bus.cout_o, v[i][1]);
      end
`ifdef ALU_FLAGS_EN
      n_checks++;
      if (bus.ovf_o !== v[i][0]) begin
        n_fail++;
        $display("FAIL %s[%0d] ovf_o: got %b expected %b", name, i, bus.ovf_o, v[i][0]);
      end
      n_checks++;
      if (bus.zero_o !== (v[i][5:2] == 4'h0)) begin
        n_fail++;
        $display("FAIL %s[%0d] zero_o: got %b expected %b", name, i, bus.zero_o, (v[i][5:2] == 4'h0));
      end
`endif
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.instr_i = 4'h0;
    bus.a_i     = 4'hF;
    bus.b_i     = 4'h1;
    bus.cin_i   = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_o !== 4'h0 || bus.cout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got out=%h cout=%b expected out=0 cout=0", bus.out_o, bus.cout_o);
    end
`ifdef ALU_FLAGS_EN
    n_checks++;
    if (bus.zero_o !== 1'b0 || bus.ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got zero=%b ovf=%b expected 0 0", bus.zero_o, bus.ovf_o);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_o !== 4'h0 || bus.cout_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got out=%h cout=%b expected out=0 cout=1", bus.out_o, bus.cout_o);
    end
    // Reset must override a live operation mid-stream.
    drive(4'h0, 4'h2, 4'h3, 1'b0);
    n_checks++;
    if (bus.out_o !== 4'h5) begin
      n_fail++;
      $display("FAIL reset_pre_op: got out=%h expected 5", bus.out_o);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.instr_i = 4'h6;
    bus.a_i     = 4'hA;
    bus.b_i     = 4'h3;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_o !== 4'h0 || bus.cout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wins: got out=%h cout=%b expected out=0 cout=0", bus.out_o, bus.cout_o);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_arith();
    logic [18:0] v[$];
    v = '{
      {4'h0, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0},
      {4'h0, 4'h7, 4'h8, 1'b1, 4'h0, 1'b1, 1'b0},
      {4'h0, 4'h2, 4'h3, 1'b1, 4'h6, 1'b0, 1'b0},
      {4'h0, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1},
      {4'h1, 4'h5, 4'h3, 1'b1, 4'h2, 1'b1, 1'b0},
      {4'h1, 4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0},
      {4'h1, 4'h5, 4'h3, 1'b0, 4'h1, 1'b1, 1'b0},
      {4'h1, 4'h8, 4'h1, 1'b1, 4'h7, 1'b1, 1'b1},
      {4'h2, 4'hF, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0},
      {4'h2, 4'h3, 4'h0, 1'b1, 4'h4, 1'b0, 1'b0},
      {4'h2, 4'h7, 4'h0, 1'b0, 4'h8, 1'b0, 1'b1},
      {4'h3, 4'h0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0},
      {4'h3, 4'h5, 4'h0, 1'b0, 4'h4, 1'b1, 1'b0},
      {4'h3, 4'h8, 4'h0, 1'b0, 4'h7, 1'b1, 1'b1}
    };
    run_vectors("arith", v);
  endtask

  task automatic test_logic();
    logic [18:0] v[$];
    v = '{
      {4'h4, 4'hA, 4'h6, 1'b1, 4'h2, 1'b0, 1'b0},
      {4'h5, 4'hA, 4'h5, 1'b1, 4'hF, 1'b0, 1'b0},
      {4'h6, 4'hA, 4'h6, 1'b1, 4'hC, 1'b0, 1'b0},
      {4'h6, 4'h9, 4'h9, 1'b0, 4'h0, 1'b0, 1'b0},
      {4'h7, 4'hA, 4'h0, 1'b1, 4'h5, 1'b0, 1'b0},
      {4'h8, 4'h3, 4'hC, 1'b1, 4'h3, 1'b0, 1'b0},
      {4'h9, 4'h3, 4'h9, 1'b1, 4'h9, 1'b0, 1'b0}
    };
    run_vectors("logic", v);
  endtask

  task automatic test_shift();
    logic [18:0] v[$];
    v = '{
      {4'hA, 4'h9, 4'h0, 1'b1, 4'h3, 1'b1, 1'b0},
      {4'hB, 4'h6, 4'h0, 1'b1, 4'hB, 1'b0, 1'b0},
      {4'hB, 4'h9, 4'h0, 1'b0, 4'h4, 1'b1, 1'b0},
      {4'hC, 4'h8, 4'h0, 1'b0, 4'hC, 1'b0, 1'b0},
      {4'hC, 4'h5, 4'h0, 1'b1, 4'h2, 1'b1, 1'b0},
      {4'hD, 4'h5, 4'h0, 1'b1, 4'hA, 1'b0, 1'b0},
      {4'hD, 4'h9, 4'h0, 1'b0, 4'h3, 1'b1, 1'b0},
      {4'hE, 4'h1, 4'h0, 1'b0, 4'h8, 1'b1, 1'b0},
      {4'hE, 4'h6, 4'h0, 1'b1, 4'h3, 1'b0, 1'b0}
    };
    run_vectors("shift", v);
  endtask

  task automatic test_compare();
    logic [18:0] v[$];
    v = '{
      {4'hF, 4'h3, 4'h9, 1'b0, 4'h1, 1'b0, 1'b0},
      {4'hF, 4'h9, 4'h9, 1'b1, 4'h0, 1'b1, 1'b0},
      {4'hF, 4'h9, 4'h3, 1'b0, 4'h0, 1'b0, 1'b0},
      {4'hF, 4'h7, 4'h8, 1'b0, 4'h1, 1'b0, 1'b0}
    };
    run_vectors("sltu", v);
  endtask

  task automatic test_back_to_back();
    drive(4'h4, 4'hA, 4'h6, 1'b0);
    n_checks++;
    if (bus.out_o !== 4'h2) begin
      n_fail++;
      $display("FAIL b2b_and: got %h expected 2", bus.out_o);
    end
    drive(4'h6, 4'hA, 4'h6, 1'b0);
    n_checks++;
    if (bus.out_o !== 4'hC) begin
      n_fail++;
      $display("FAIL b2b_xor: got %h expected C", bus.out_o);
    end
    drive(4'h0, 4'h4, 4'h4, 1'b1);
    n_checks++;
    if (bus.out_o !== 4'h9 || bus.cout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_add: got out=%h cout=%b expected out=9 cout=0", bus.out_o, bus.cout_o);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_compare();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
